// File: rtl/imem_program_loader.sv
// Program loader: packs a byte stream (MSB first) into instruction-memory writes,
// holding the pipeline off until the halt word has been stored.
//
// state | meaning
// IDLE  | waiting for i_start, pipeline disabled
// RECV  | accepting bytes into the word register
// WRITE | one-cycle write strobe for the assembled word
// DONE  | halt word written, pipeline enabled
// ERROR | TAM words written without a halt word
module imem_program_loader #(
    parameter int              NB        = 32,
    parameter int              TAM       = 256,
    parameter int              CW        = 9,
    parameter logic [NB-1:0]   HALT_WORD = 32'hFFFFFFFF
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_start,
    input  logic          i_byte_valid,
    input  logic [7:0]    i_byte,
    output logic          o_byte_ready,
    output logic          o_instruction_write,
    output logic [NB-1:0] o_address_memory_ins,
    output logic [NB-1:0] o_instruction,
    output logic          o_pipeline_enable,
    output logic          o_busy,
    output logic          o_done,
    output logic          o_overflow,
    output logic [CW-1:0] o_word_count
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RECV  = 3'd1,
        WRITE = 3'd2,
        DONE  = 3'd3,
        ERROR = 3'd4
    } state_t;

    localparam logic [CW-1:0] LAST_WORD = CW'(TAM - 1);

    state_t        state;
    state_t        state_next;
    logic [1:0]    byte_cnt;
    logic [NB-1:0] word_reg;
    logic [NB-1:0] addr;
    logic [CW-1:0] word_count;
    logic          load_start;
    logic          byte_take;

    assign load_start = i_start && (state == IDLE || state == DONE || state == ERROR);
    assign byte_take  = (state == RECV) && i_byte_valid;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (i_start) state_next = RECV;
            end
            RECV: begin
                if (byte_take && byte_cnt == 2'd3) state_next = WRITE;
            end
            WRITE: begin
                // halt wins over overflow when the halt lands in the last slot
                if (word_reg == HALT_WORD)       state_next = DONE;
                else if (word_count == LAST_WORD) state_next = ERROR;
                else                              state_next = RECV;
            end
            DONE, ERROR: begin
                if (i_start) state_next = RECV;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            byte_cnt   <= '0;
            word_reg   <= '0;
            addr       <= '0;
            word_count <= '0;
        end else if (load_start) begin
            byte_cnt   <= '0;
            word_reg   <= '0;
            addr       <= '0;
            word_count <= '0;
        end else if (byte_take) begin
            word_reg <= {word_reg[NB-9:0], i_byte};
            byte_cnt <= byte_cnt + 2'd1;
        end else if (state == WRITE) begin
            word_count <= word_count + CW'(1);
            addr       <= addr + NB'(4);
        end
    end

    assign o_byte_ready         = (state == RECV);
    assign o_instruction_write  = (state == WRITE);
    assign o_busy               = (state == RECV) || (state == WRITE);
    assign o_done               = (state == DONE);
    assign o_overflow           = (state == ERROR);
    assign o_pipeline_enable    = (state == DONE);
    assign o_address_memory_ins = addr;
    assign o_instruction        = word_reg;
    assign o_word_count         = word_count;

endmodule
